uio_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared bidirectional `uio` pins of `tt_um_driving_it_2025`. Several internal requesters each present output data and an output-enable mask. The block grants the pins to one requester at a time and registers that requester's data onto `uio_out`/`uio_oe`. On every change of owner it inserts a bus-turnaround gap with all pins tri-stated, and it bounds burst length so that no requester can starve the others.

---
 rtl/uio_bus_if.sv | 16 +
 rtl/uio_bus_arbiter.sv | 119 +++++++++++
 tb/tb_uio_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uio_bus_if.sv
// Shared uio pin bus between the requesters (master) and the arbiter (slave).
interface uio_bus_if #(parameter int NREQ = 3);
  logic                 ena;
  logic [NREQ-1:0]      req;
  logic [NREQ*8-1:0]    req_dout;
  logic [NREQ*8-1:0]    req_oe;
  logic [NREQ-1:0]      gnt;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;
  logic                 busy;

  modport master (output ena, req, req_dout, req_oe,
                  input  gnt, uio_out, uio_oe, busy);
  modport slave  (input  ena, req, req_dout, req_oe,
                  output gnt, uio_out, uio_oe, busy);
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pins with a tri-state turnaround gap between
// owners and a burst limit that pre-empts an owner when others are waiting.
module uio_bus_arbiter #(
  parameter int NREQ        = 3,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  uio_bus_if.slave   bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t          state;
  logic [PW-1:0]   owner, ptr;
  logic [CW-1:0]   bcnt;
  logic [TW-1:0]   tcnt;
  logic [NREQ-1:0] gnt_q;
  logic [7:0]      out_q, oe_q;

  logic [NREQ-1:0] ereq, owner_oh, win_oh;
  logic [PW-1:0]   win, ptr_nxt;
  logic            win_vld, others, rel, preempt;
  logic [7:0]      win_dout, win_oe, own_dout, own_oe;

  assign ereq = bus.req & {NREQ{bus.ena}};

  // Walk from ptr downward in priority so the nearest set bit after ptr wins last.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (ereq[(int'(ptr) + k) % NREQ]) begin
        win_vld = 1'b1;
        win     = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign win_oh   = NREQ'(1) << win;
  assign ptr_nxt  = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
  assign win_dout = bus.req_dout[int'(win)*8 +: 8];
  assign win_oe   = bus.req_oe[int'(win)*8 +: 8];

  assign owner_oh = NREQ'(1) << owner;
  assign own_dout = bus.req_dout[int'(owner)*8 +: 8];
  assign own_oe   = bus.req_oe[int'(owner)*8 +: 8];
  assign others   = |(ereq & ~owner_oh);
  assign rel      = ~|(ereq & owner_oh);
  assign preempt  = (bcnt == CW'(MAX_BURST)) && others;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      owner <= '0;
      ptr   <= '0;
      bcnt  <= '0;
      tcnt  <= '0;
      gnt_q <= '0;
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            state <= S_GRANT;
            owner <= win;
            ptr   <= ptr_nxt;
            bcnt  <= CW'(1);
            gnt_q <= win_oh;
            out_q <= win_dout;
            oe_q  <= win_oe;
          end
        end
        S_GRANT: begin
          if (rel || preempt) begin
            state <= S_TURN;
            tcnt  <= '0;
            gnt_q <= '0;
            out_q <= '0;
            oe_q  <= '0;
          end else begin
            out_q <= own_dout;
            oe_q  <= own_oe;
            if (bcnt != CW'(MAX_BURST)) bcnt <= bcnt + CW'(1);
          end
        end
        S_TURN: begin
          // Arbitrate in the last gap cycle so the next owner drives right after it.
          if (tcnt == TW'(TURN_CYCLES - 1)) begin
            if (win_vld) begin
              state <= S_GRANT;
              owner <= win;
              ptr   <= ptr_nxt;
              bcnt  <= CW'(1);
              gnt_q <= win_oh;
              out_q <= win_dout;
              oe_q  <= win_oe;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.uio_out = out_q;
  assign bus.uio_oe  = oe_q;
  assign bus.busy    = (state != S_IDLE);
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter at default parameters (3 requesters).
module tb_uio_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  uio_bus_if #(.NREQ(3)) bus();

  uio_bus_arbiter #(.NREQ(3), .TURN_CYCLES(1), .MAX_BURST(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic       en;
    logic [2:0] rq;
    logic [7:0] d0;
    logic [2:0] eg;
    logic [7:0] eo;
    logic [7:0] eoe;
    logic       eb;
  } vec_t;

  vec_t tbl[13];
  logic [7:0] dd[3];
  logic [7:0] oo[3];

  task automatic drive(input logic rn, input logic en, input logic [2:0] rq);
    rst_n    = rn;
    bus.ena  = en;
    bus.req  = rq;
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot0(bus.gnt) || (bus.uio_oe != 8'h00 && bus.gnt == 3'b000)) begin
      errors++;
      $display("FAIL invariant: gnt=%b uio_oe=%h (need one-hot/zero gnt, oe only when granted)",
               bus.gnt, bus.uio_oe);
    end
  endtask

  task automatic chk(input string nm, input logic [2:0] eg, input logic [7:0] eo,
                     input logic [7:0] eoe, input logic eb);
    checks++;
    if (bus.gnt !== eg || bus.uio_out !== eo || bus.uio_oe !== eoe || bus.busy !== eb) begin
      errors++;
      $display("FAIL %s: got gnt=%b out=%h oe=%h busy=%b, need gnt=%b out=%h oe=%h busy=%b",
               nm, bus.gnt, bus.uio_out, bus.uio_oe, bus.busy, eg, eo, eoe, eb);
    end
  endtask

  initial begin
    dd[0] = 8'hA5; dd[1] = 8'h3C; dd[2] = 8'hC3;
    oo[0] = 8'hFF; oo[1] = 8'h0F; oo[2] = 8'hF0;
    bus.ena = 1'b1;
    bus.req = 3'b000;
    bus.req_dout = {8'hC3, 8'h3C, 8'hA5};
    bus.req_oe   = {8'hF0, 8'h0F, 8'hFF};

    //           rn en  rq      d0     eg      eo     eoe    eb
    tbl[0]  = '{1'b0, 1'b1, 3'b000, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 3'b000, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 3'b001, 8'hA5, 3'b001, 8'hA5, 8'hFF, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 3'b001, 8'h5A, 3'b001, 8'h5A, 8'hFF, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 3'b000, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 3'b000, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 3'b001, 8'hA5, 3'b001, 8'hA5, 8'hFF, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 3'b011, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 3'b011, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'b011, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 3'b011, 8'hA5, 3'b010, 8'h3C, 8'h0F, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 3'b000, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 3'b000, 8'hA5, 3'b000, 8'h00, 8'h00, 1'b0};

    for (int i = 0; i < 13; i++) begin
      bus.req_dout[7:0] = tbl[i].d0;
      drive(tbl[i].rn, tbl[i].en, tbl[i].rq);
      chk($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eo, tbl[i].eoe, tbl[i].eb);
    end
    bus.req_dout[7:0] = 8'hA5;

    // Full contention: 8-cycle bursts rotating 0,1,2,0 with one-cycle gaps.
    drive(1'b0, 1'b1, 3'b000);
    chk("rot_reset", 3'b000, 8'h00, 8'h00, 1'b0);
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 8; c++) begin
        drive(1'b1, 1'b1, 3'b111);
        chk($sformatf("rot_g%0d_c%0d", g, c), 3'b001 << (g % 3), dd[g % 3], oo[g % 3], 1'b1);
      end
      drive(1'b1, 1'b1, 3'b111);
      chk($sformatf("rot_gap%0d", g), 3'b000, 8'h00, 8'h00, 1'b1);
    end

    // Lone requester holds the bus past MAX_BURST; a newcomer pre-empts at once.
    drive(1'b0, 1'b1, 3'b000);
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1, 3'b001);
      chk($sformatf("solo_c%0d", c), 3'b001, 8'hA5, 8'hFF, 1'b1);
    end
    drive(1'b1, 1'b1, 3'b011);
    chk("solo_preempt", 3'b000, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 3'b011);
    chk("solo_next", 3'b010, 8'h3C, 8'h0F, 1'b1);

    // Owner 1 releases in the same cycle its burst limit is hit, with 2 pending.
    drive(1'b0, 1'b1, 3'b000);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b1, 3'b010);
      chk($sformatf("relpre_c%0d", c), 3'b010, 8'h3C, 8'h0F, 1'b1);
    end
    drive(1'b1, 1'b1, 3'b100);
    chk("relpre_turn", 3'b000, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 3'b100);
    chk("relpre_gnt2", 3'b100, 8'hC3, 8'hF0, 1'b1);
    drive(1'b1, 1'b1, 3'b100);
    chk("relpre_hold", 3'b100, 8'hC3, 8'hF0, 1'b1);

    // Reset mid-burst clears everything and restarts the pointer at 0.
    drive(1'b0, 1'b1, 3'b000);
    drive(1'b1, 1'b1, 3'b111);
    drive(1'b1, 1'b1, 3'b111);
    drive(1'b1, 1'b1, 3'b111);
    chk("mid_pre", 3'b001, 8'hA5, 8'hFF, 1'b1);
    drive(1'b0, 1'b1, 3'b111);
    chk("mid_reset", 3'b000, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 3'b111);
    chk("mid_regrant", 3'b001, 8'hA5, 8'hFF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
